// File: rtl/serializer_arbiter_pkg.sv
// Shared types and default sizes for serializer_arbiter and its round-robin arbiter.
package serializer_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap-around.
module rr_arbiter
    import serializer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any_gnt
);

    // One spare bit so ptr + offset can exceed NUM_REQ before wrapping.
    logic [IDX_W:0] cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + i[IDX_W:0];
            if (cand >= NUM_REQ[IDX_W:0]) begin
                cand = cand - NUM_REQ[IDX_W:0];
            end
            if (!any_gnt && req[cand[IDX_W-1:0]]) begin
                any_gnt                = 1'b1;
                idx                    = cand[IDX_W-1:0];
                gnt[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin front end sharing one serializer between NUM_REQ requesters.
// Optional watchdog on the serializer handshake: define SERIALIZER_ARBITER_TIMEOUT_EN.
module serializer_arbiter
    import serializer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      ser_start_o,
    output logic [DATA_W-1:0]         ser_data_o,
    input  logic                      ser_done_i,
    output logic [IDX_W-1:0]          grant_id_o,
    output logic                      busy_o,
    output logic                      err_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .any_gnt (arb_any)
    );

`ifdef SERIALIZER_ARBITER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Fires on the TIMEOUT-th WAIT cycle; a coincident done takes priority.
    assign timeout = (state_q == WAIT) && !ser_done_i && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == START) begin
                wd_q <= '0;
            end else if (state_q == WAIT) begin
                wd_q <= wd_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign timeout        = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        hold_d      = hold_q;
        req_ready_o = '0;
        ser_start_o = 1'b0;
        ser_data_o  = '0;
        busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_o = arb_gnt;
                    gid_d       = arb_idx;
                    hold_d      = req_data_i[arb_idx*DATA_W +: DATA_W];
                    state_d     = START;
                end
            end
            START: begin
                ser_start_o = 1'b1;
                ser_data_o  = hold_q;
                busy_o      = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                ser_data_o = hold_q;
                busy_o     = 1'b1;
                if (ser_done_i || timeout) begin
                    state_d = IDLE;
                    ptr_d   = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The ready path is combinational from req_valid_i, so mask it while reset is held.
        if (!rst_i) begin
            req_ready_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            hold_q  <= hold_d;
        end
    end

    assign grant_id_o = gid_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Randomized scoreboard bench for serializer_arbiter with a queue-based round-robin model.
module tb_serializer_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           ser_start;
    logic [W-1:0]   ser_data;
    logic           ser_done;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic           err;

    serializer_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .ser_start_o (ser_start),
        .ser_data_o  (ser_data),
        .ser_done_i  (ser_done),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           cyc;
    } txn_t;

    txn_t         exp_q[$];
    int           grant_log[$];
    int           total = 0;
    int           passed = 0;
    int           cyc = 0;
    int           model_ptr = 0;
    int           n_acc = 0;
    int           n_start = 0;
    logic [N-1:0] vld = '0;
    logic [W-1:0] dat [N];
    logic [N-1:0] acc_mask = '0;
    bit           persist = 0;
    bit           random_mode = 0;
    bit           rand_lat = 0;
    bit           never_done = 0;
    bit           spur_start = 0;
    bit           spur_idle_req = 0;
    int           lat = 4;
    int           rem = 0;
    logic         next_done = 1'b0;
    bit           inflight = 0;
    int           wcnt = 0;
    logic [W-1:0] cur_data;
    int           cur_id = 0;
    bit           exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic apply();
        req_valid = vld;
        for (int k = 0; k < N; k++) req_data[k*W +: W] = dat[k];
    endtask

    // One clock of stimulus: retire accepted words, optionally churn requesters, drive ports.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (acc_mask[k] && !persist) vld[k] = 1'b0;
        acc_mask = '0;
        if (random_mode) begin
            for (int k = 0; k < N; k++) begin
                if (!vld[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        vld[k] = 1'b1;
                        dat[k] = W'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    vld[k] = 1'b0;
                end
            end
        end
        apply();
        ser_done = next_done | spur_idle_req;
        spur_idle_req = 0;
    endtask

    task automatic reset_checks();
        check("rst_ready", req_ready, 0);
        check("rst_start", ser_start, 0);
        check("rst_data", ser_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        vld = '1;
        apply();
        ser_done = 1'b0;
        @(negedge clk);
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        vld = '0;
        apply();
        exp_q.delete();
        model_ptr = 0;
        acc_mask = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int g = 0; g < budget && !ok; g++) begin
            step();
            ok = (vld == '0) && (exp_q.size() == 0) && !inflight && !busy;
        end
        check({"drain_", name}, ok, 1);
    endtask

    // Requesters: on every acceptance, predict the winner and queue the expected transfer.
    initial begin : requester
        int   k;
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst_n && req_ready != '0) begin
                k = -1;
                for (int j = 0; j < N; j++)
                    if (k < 0 && req_valid[(model_ptr + j) % N]) k = (model_ptr + j) % N;
                check("ready_winner", req_ready, (k < 0) ? 0 : (1 << k));
                if (k >= 0) begin
                    t.id = k;
                    t.data = req_data[k*W +: W];
                    t.cyc = cyc;
                    exp_q.push_back(t);
                    acc_mask[k] = 1'b1;
                    model_ptr = (k + 1) % N;
                    n_acc++;
                end
            end
        end
    end

    // Serializer model: done pulse a fixed or random number of cycles after each start.
    initial begin : serializer
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rem = 0;
                next_done = 1'b0;
            end else begin
                if (ser_start) rem = never_done ? 0 : (rand_lat ? int'($urandom_range(1, 6)) : lat);
                next_done = (rem == 1) || (spur_start && req_ready != '0);
                if (rem > 0) rem--;
            end
        end
    end

    // Monitor: pops the scoreboard on each start and checks the transaction until it ends.
    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight = 0;
                exp_err = 0;
            end else begin
                check("err", err, exp_err);
                if (ser_start) begin
                    n_start++;
                    grant_log.push_back(int'(grant_id));
                    check("start_has_txn", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        check("start_grant_id", grant_id, t.id);
                        check("start_data", ser_data, t.data);
                        check("start_latency", cyc, t.cyc + 1);
                        check("start_busy", busy, 1);
                        check("start_ready", req_ready, 0);
                        cur_data = t.data;
                        cur_id = t.id;
                    end
                    inflight = 1;
                    wcnt = 0;
                end else if (inflight) begin
                    check("wait_busy", busy, 1);
                    check("wait_data", ser_data, cur_data);
                    check("wait_grant_id", grant_id, cur_id);
                    check("wait_ready", req_ready, 0);
                    wcnt++;
                    if (ser_done) begin
                        inflight = 0;
                    end
`ifdef SERIALIZER_ARBITER_TIMEOUT_EN
                    else if (wcnt == TO) begin
                        inflight = 0;
                        exp_err = 1;
                    end
`endif
                end else begin
                    check("idle_busy", busy, 0);
                    check("idle_grants_when_valid", req_ready != '0, req_valid != '0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin : main
        int b;
        int s0;
        int exp_order[5];
        int exp_wrap[2];
        bit ok;

        rst_n = 1'b0;
        ser_done = 1'b0;
        vld = '1;
        for (int k = 0; k < N; k++) dat[k] = W'(8'hF0 + k);
        apply();
        @(negedge clk);
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        vld = '0;
        apply();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of WAIT abandons the transfer.
        lat = 20;
        vld[1] = 1'b1;
        dat[1] = 8'h3C;
        ok = 0;
        for (int g = 0; g < 50 && !ok; g++) begin
            step();
            ok = inflight && wcnt >= 3;
        end
        check("reach_wait", ok, 1);
        do_reset();
        repeat (4) step();

        // Single transfer.
        lat = 4;
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        b = grant_log.size();
        drain(50, "single");
        check("single_count", grant_log.size() - b, 1);

        // Contention from pointer 0: rounds of 0,1,2,3 then 0.
        do_reset();
        lat = 8;
        persist = 1;
        vld = '1;
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        b = grant_log.size();
        s0 = n_acc;
        for (int g = 0; g < 400 && n_acc < s0 + 5; g++) step();
        persist = 0;
        vld = '0;
        apply();
        drain(100, "contention");
        exp_order = '{0, 1, 2, 3, 0};
        check("contention_count", grant_log.size() - b, 5);
        for (int i = 0; i < 5; i++)
            if (b + i < grant_log.size()) check("contention_order", grant_log[b + i], exp_order[i]);

        // Wrap-around: pointer lands on 3, then requesters 1 and 3 contend.
        do_reset();
        lat = 3;
        vld[2] = 1'b1;
        dat[2] = 8'h5A;
        drain(50, "wrap_setup");
        vld[1] = 1'b1; dat[1] = 8'h61;
        vld[3] = 1'b1; dat[3] = 8'h63;
        b = grant_log.size();
        drain(100, "wrap");
        exp_wrap = '{3, 1};
        check("wrap_count", grant_log.size() - b, 2);
        for (int i = 0; i < 2; i++)
            if (b + i < grant_log.size()) check("wrap_order", grant_log[b + i], exp_wrap[i]);

        // Spurious done in IDLE and in START.
        s0 = n_start;
        spur_idle_req = 1;
        repeat (3) step();
        check("spur_idle_no_start", n_start - s0, 0);
        spur_start = 1;
        lat = 5;
        vld[0] = 1'b1;
        dat[0] = 8'hC3;
        drain(50, "spurious");
        spur_start = 0;
        check("spur_one_start", n_start - s0, 1);

        // Randomized traffic with random serializer latency.
        random_mode = 1;
        rand_lat = 1;
        s0 = n_acc;
        for (int g = 0; g < 3000 && n_acc < s0 + 40; g++) step();
        check("random_progress", n_acc - s0 >= 40, 1);
        random_mode = 0;
        drain(400, "random");
        rand_lat = 0;
        lat = 4;

        // Serializer that never answers.
`ifdef SERIALIZER_ARBITER_TIMEOUT_EN
        never_done = 1;
        vld[0] = 1'b1; dat[0] = 8'h0F;
        vld[1] = 1'b1; dat[1] = 8'hF0;
        s0 = n_start;
        for (int g = 0; g < 20 && n_start == s0; g++) step();
        never_done = 0;
        drain(300, "timeout");
        check("timeout_next_granted", n_start - s0, 2);
        check("err_sticky", err, 1);
        repeat (5) step();
        check("err_still_set", err, 1);
`else
        never_done = 1;
        vld[0] = 1'b1;
        dat[0] = 8'h0F;
        repeat (100) step();
        check("no_timeout_busy", busy, 1);
        check("no_timeout_err", err, 0);
        never_done = 0;
        do_reset();
        repeat (3) step();
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
- Round-robin controller that shares one serializer datapath between NUM_REQ requesters.
- Accepts one parallel word per transaction from the winning requester and holds it in a holding register.
- Pulses the serializer start, then waits for the serializer's completion before granting again.
- Sits between client blocks and the serializer; the serializer's start/data inputs are driven only by this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, word width handed to the serializer.
- TIMEOUT, 64, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester word valid.
- req_data_i  input  NUM_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  output  NUM_REQ  one-hot acceptance pulse.
- ser_start_o  output  1  one-cycle start pulse to the serializer.
- ser_data_o  output  DATA_W  word presented to the serializer.
- ser_done_i  input  1  serializer completion pulse.
- grant_id_o  output  $clog2(NUM_REQ)  index of the requester being served.
- busy_o  output  1  high whenever state is not IDLE.
- err_o  output  1  sticky timeout flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, rr pointer=0, holding register=0.
  - All outputs 0.
  - A reset mid-transaction abandons the transaction; no ready or start is emitted afterwards.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - If any req_valid_i is set, pick the first set bit scanning upward from the pointer, with wrap-around.
  - In that same cycle: req_ready_o[winner]=1 (combinational), capture the word and winner index, next state=START.
  - Requesters see handshake completion when valid&ready are both high.
  - If no valid bit is set, stay in IDLE with all outputs 0.
- START:
  - ser_start_o=1 for exactly one cycle; ser_data_o=holding register.
  - Next state=WAIT.
  - ser_done_i is ignored in START.
- WAIT:
  - ser_data_o stays stable.
  - On ser_done_i=1, return to IDLE and set pointer=(winner+1) mod NUM_REQ.
- Gaps and latency:
  - Minimum gap between two start pulses is 3 cycles plus the serializer latency.
  - At least one IDLE cycle always separates transactions.
- Outputs by state:
  - req_ready_o is 0 outside IDLE.
  - grant_id_o is valid in START and WAIT and holds its last value in IDLE.
  - busy_o=1 in START and WAIT.
- Fairness:
  - A requester that keeps valid high is served at most once per NUM_REQ grants while others are waiting.
  - A single active requester is served back-to-back.
- Requester rules:
  - Dropping req_valid_i before ready is legal; that requester simply loses the arbitration.
  - req_data_i is sampled only in the accept cycle.
- A ser_done_i pulse in IDLE is ignored.

Optional Feature:
- Macro: SERIALIZER_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without ser_done_i, the FSM returns to IDLE, the pointer advances as for a normal completion, and err_o is set.
  - err_o stays high until reset.
  - If ser_done_i arrives in the same cycle as the timeout, done wins and err_o is not set.
- Without the macro: no watchdog counter is built, err_o=0, and WAIT lasts until ser_done_i with no time limit.

Decomposition:
- Package serializer_arbiter_pkg holds:
  - state enum type (IDLE, START, WAIT) on 2 bits;
  - default constants NUM_REQ_DEF and DATA_W_DEF.
- Sub-module rr_arbiter (combinational):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, binary index, any-grant.
  - Parameterised by NUM_REQ and reused by other shared-resource blocks.

Test Plan:
- Reset and single transfer: assert reset mid-WAIT -> all outputs 0 next sample. Then release reset; req 0 valid with data 0xA5 -> ready[0] same cycle, ser_start_o one cycle later with ser_data_o=0xA5, busy_o until ser_done_i.
- Contention: all four requesters valid with 0x11/0x22/0x33/0x44, done returned 8 cycles after each start -> grant order 0,1,2,3, then 0 again; each word appears on ser_data_o exactly once per round.
- Wrap-around: pointer=3 with requesters 1 and 3 valid -> 3 served first, then 1.
- Spurious done: ser_done_i in IDLE and in START -> ignored; the transaction finishes only on a done received in WAIT.
- Timeout with macro, TIMEOUT=64: never return done -> FSM returns to IDLE after 64 WAIT cycles, err_o=1 and stays high, next requester is granted. Without the macro, same stimulus -> busy_o stays high indefinitely and err_o=0.
